// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory end of the core's load/store port. A requester holds req high until
// a one-cycle ready pulse. The responder inserts WAIT_CYCLES wait states after
// accepting a request. It serves a word-addressed RAM and a small register
// window at MMIO_BASE:
//   +0x0  free-running cycle counter (read-only; writes are silently ignored)
//   +0x4  result register (read/write; a write pulses result_valid)
//   +0x8  status; bit0 is sticky "result written", and writing 1 clears it
// Misaligned or unmapped accesses complete with err=1, change no state and
// return rdata=0.
//
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   req            request, held until ready
//   we             1 = store, 0 = load (sampled with req)
//   addr           byte address (sampled with req)
//   wdata          store data (sampled with req)
//   rdata          load data, nonzero only in the ready cycle
//   ready          one-cycle completion pulse
//   err            access error, valid with ready
//   result         current result register value
//   result_valid   one-cycle pulse when the result register is written
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] result,
  output logic        result_valid
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  localparam logic [31:0] CNT_ADDR  = MMIO_BASE;
  localparam logic [31:0] RES_ADDR  = MMIO_BASE + 32'h4;
  localparam logic [31:0] STS_ADDR  = MMIO_BASE + 32'h8;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  wcnt;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] cycle_cnt;
  logic [31:0] result_q;
  logic        status_q;
  logic [31:0] rdata_q;
  logic        err_q, rv_q;
  logic [31:0] mem [DEPTH];

  // Transaction view: with zero wait states the commit edge is the same edge
  // that samples req, so the live inputs are used in IDLE and the latched
  // copies everywhere else.
  logic        t_we;
  logic [31:0] t_addr, t_wdata;
  logic [AW-1:0] t_idx;
  logic        hit_ram, hit_cnt, hit_res, hit_sts, t_err;
  logic        commit, do_write, sts_set, sts_clr;
  logic [31:0] rd_val;

  always_comb begin
    t_we    = we_q;
    t_addr  = addr_q;
    t_wdata = wdata_q;
    if (state == ST_IDLE) begin
      t_we    = we;
      t_addr  = addr;
      t_wdata = wdata;
    end
  end

  assign t_idx   = t_addr[AW+1:2];
  assign hit_ram = (t_addr < RAM_BYTES);
  assign hit_cnt = (t_addr == CNT_ADDR);
  assign hit_res = (t_addr == RES_ADDR);
  assign hit_sts = (t_addr == STS_ADDR);
  assign t_err   = (t_addr[1:0] != 2'b00) || !(hit_ram || hit_cnt || hit_res || hit_sts);

  // Every write and read capture happens on the edge that enters RESP.
  assign commit   = (state_nx == ST_RESP) && (state != ST_RESP);
  assign do_write = commit && !t_err && t_we;
  assign sts_set  = do_write && hit_res;
  assign sts_clr  = do_write && hit_sts && t_wdata[0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    rd_val = 32'h0;
    if (hit_ram)      rd_val = mem[t_idx];
    else if (hit_cnt) rd_val = cycle_cnt;
    else if (hit_res) rd_val = result_q;
    else if (hit_sts) rd_val = {31'h0, status_q};
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req) state_nx = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wcnt <= 4'd1) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wcnt      <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      cycle_cnt <= 32'h0;
      result_q  <= 32'h0;
      status_q  <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state     <= state_nx;
      cycle_cnt <= cycle_cnt + 32'd1;

      if (state == ST_IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        wcnt    <= WAIT_INIT;
      end else if (state == ST_WAIT) begin
        wcnt <= wcnt - 4'd1;
      end

      // Response registers are loaded on the commit edge and cleared on every
      // other edge, so they are nonzero only during RESP.
      rdata_q <= (commit && !t_err && !t_we) ? rd_val : 32'h0;
      err_q   <= commit && t_err;
      rv_q    <= sts_set;

      if (sts_set) result_q <= t_wdata;
      // A set in the same window as a clear wins.
      status_q <= sts_set | (status_q & ~sts_clr);
    end
  end

  // NOTE: RAM contents are deliberately left out of reset so the array maps
  // onto plain memory; only the control path above is reset.
  always_ff @(posedge clk) begin
    if (do_write && hit_ram) mem[t_idx] <= t_wdata;
  end

  assign rdata        = rdata_q;
  assign ready        = (state == ST_RESP);
  assign err          = err_q;
  assign result       = result_q;
  assign result_valid = rv_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the processor's load/store port, converted from a combinational access to a req/ready handshake with configurable wait states.
- Holds a word-addressed RAM plus a small memory-mapped register window: free-running cycle counter, result register, sticky status.
- Sits between the multicycle/pipelined core's load/store unit and the testbench. The bench observes results through the result_* outputs instead of snooping raw bus writes.

Parameters:
- DEPTH, 64, number of 32-bit RAM words; legal addresses 0 .. 4*DEPTH-1.
- WAIT_CYCLES, 1, extra cycles between request acceptance and ready; legal range 0..15.
- MMIO_BASE, 32'h0000_0400, base byte address of the register window; must be at or above 4*DEPTH.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req  in  1  request; held high by the requester until ready
- we  in  1  1 = store, 0 = load; sampled with req
- addr  in  32  byte address; sampled with req
- wdata  in  32  store data; sampled with req
- rdata  out  32  load data; valid only while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  valid with ready; 1 = misaligned or unmapped access
- result  out  32  current value of the result register
- result_valid  out  1  one-cycle pulse when the result register is written

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values: all outputs are 0, FSM is in IDLE, the counter is 0 and the status register is 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req=1, latch addr, we and wdata, and load wcnt with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT: decrement wcnt each cycle; go to RESP when wcnt reaches 1.
- RESP: ready=1 for exactly one cycle, then return to IDLE.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the edge that samples req.
- Busy behaviour: req, addr, we and wdata are ignored outside IDLE; the latched copies are used.
- Back-to-back: a req still high in the cycle after ready is treated as a new transaction. Requesters drop req in the ready cycle.
- Store commit: RAM and register writes commit on the edge that enters RESP, so a load issued next sees the new data.
- Load data: rdata is driven from the latched address during RESP only, and is 0 at all other times.
- Decode, RAM: latched addr < 4*DEPTH selects RAM word addr[31:2].
- Decode, counter: MMIO_BASE+0x0 is the cycle counter.
  - Read-only; writes are ignored without error.
  - 32-bit; increments every cycle after reset and wraps from 0xFFFFFFFF to 0.
  - A read returns the value on the edge entering RESP.
- Decode, result register: MMIO_BASE+0x4 is read/write.
  - A write pulses result_valid in the RESP cycle and sets status bit0.
- Decode, status: MMIO_BASE+0x8.
  - bit0 is sticky "result written"; writing 1 to bit0 clears it.
  - Bits 31:1 read as 0.
  - If a result write and a clear occur in the same transaction window, the set wins. This case is impossible with a single port, but the set-wins rule is still required.
- Errors: addr[1:0]≠0, or any other address, gives err=1 with ready.
  - No state change occurs and rdata=0.
  - The latency is unchanged.
- Reset mid-transaction: the transaction aborts immediately and no write commits. No ready or result_valid pulse is emitted.

Test Plan:
- WAIT_CYCLES=1: store 0x0000_0007 to 0x60, then load 0x60 → each ready arrives 2 cycles after req is sampled, err=0, rdata=0x7 on the load.
- WAIT_CYCLES=0: store and load at 0xFC (last word of a 64-word RAM) → ready 1 cycle after req; a load of 0x100 returns err=1, rdata=0.
- Store 0x7 to MMIO_BASE+0x4 → result_valid pulses for 1 cycle with ready, result=0x7, a status read returns 0x1. Writing 0x1 to status then reads back 0x0.
- Misaligned store to 0x62 → err=1, ready pulses, and a load of 0x60 returns its old value unchanged.
- Two counter reads 10 cycles apart (WAIT_CYCLES=1) → difference is exactly 10. With the counter forced near 0xFFFFFFFF, it wraps to 0.
- Assert reset during WAIT of a store to 0x40 holding 0xAAAA_AAAA, where the word previously held 0x1234 → no ready pulse, outputs go to 0, and a later load of 0x40 returns 0x1234.
